// File: rtl/psg_env_gen_if.sv
// -----------------------------------------------------------------------------
// psg_env_gen_if
//
// Bundles the envelope generator's control inputs and level outputs so the
// register-file side and the amplitude mux side connect through one port.
//
// Signals:
//   cen256   envelope time-base strobe from the clock-enable divider
//   period   16-bit envelope period (R13:R14); 0 behaves as 1
//   shape    envelope shape {CONT, ATT, ALT, HOLD}, latched on restart
//   restart  one-clk pulse on a shape-register write
//   env      current envelope level, EW bits
//   env_end  one-clk strobe when a full ramp completes
//
// Modports:
//   master   the register-file / timing side (drives the controls)
//   slave    the envelope generator itself
// -----------------------------------------------------------------------------
interface psg_env_gen_if #(
  parameter int EW = 5
);

  logic          cen256;
  logic [15:0]   period;
  logic [3:0]    shape;
  logic          restart;
  logic [EW-1:0] env;
  logic          env_end;

  modport master (
    output cen256,
    output period,
    output shape,
    output restart,
    input  env,
    input  env_end
  );

  modport slave (
    input  cen256,
    input  period,
    input  shape,
    input  restart,
    output env,
    output env_end
  );

endinterface

// File: rtl/psg_env_gen.sv
// -----------------------------------------------------------------------------
// psg_env_gen
//
// YM2149 / AY-3-8910 compatible envelope generator. A 16-bit period divider
// turns cen256 strobes into envelope ticks; each tick advances an EW-bit step
// counter. The shape bits latched at restart decide what happens when a ramp
// finishes: stop at 0, hold at a fixed level, repeat, or repeat alternating.
//
// Parameters:
//   EW       level width; 5 gives 32 steps (YM2149), 4 gives 16 (AY-3-8910)
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   bus      psg_env_gen_if slave modport (cen256, period, shape, restart in;
//            env, env_end out)
// -----------------------------------------------------------------------------
module psg_env_gen #(
  parameter int EW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  psg_env_gen_if.slave  bus
);

  localparam logic [EW-1:0] MAX = {EW{1'b1}};

  logic [15:0]   cnt_q,     cnt_d;
  logic [EW-1:0] step_q,    step_d;
  logic          dir_q,     dir_d;
  logic          stop_q,    stop_d;
  logic          held_q,    held_d;
  logic [3:0]    shape_q,   shape_d;
  logic          env_end_q, env_end_d;

  logic [15:0]   period_eff;
  logic          tick;

  // A zero period would otherwise never tick; the hardware treats it as 1.
  assign period_eff = (bus.period == 16'd0) ? 16'd1 : bus.period;

  // Compare with >= (not ==) so shrinking the period below the current count
  // ticks on the next strobe instead of running the counter round to 65535.
  // The extra bit keeps cnt+1 from overflowing at cnt = 16'hFFFF.
  assign tick = bus.cen256 && (({1'b0, cnt_q} + 17'd1) >= {1'b0, period_eff});

  always_comb begin
    cnt_d     = cnt_q;
    step_d    = step_q;
    dir_d     = dir_q;
    stop_d    = stop_q;
    held_d    = held_q;
    shape_d   = shape_q;
    env_end_d = 1'b0;

    if (bus.cen256) begin
      cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end

    // A shape write wins over a tick landing in the same cycle.
    if (bus.restart) begin
      cnt_d   = 16'd0;
      step_d  = '0;
      dir_d   = bus.shape[2];
      stop_d  = 1'b0;
      shape_d = bus.shape;
    end else if (tick && !stop_q) begin
      if (step_q != MAX) begin
        step_d = step_q + 1'b1;
      end else begin
        env_end_d = 1'b1;
        if (!shape_q[3]) begin
          // CONT clear: every such shape parks at level 0.
          stop_d = 1'b0 | 1'b1;
          held_d = 1'b0;
        end else if (shape_q[0]) begin
          // HOLD: freeze at the end of the ramp just finished, or at the
          // opposite end when ALT flips it.
          stop_d = 1'b1;
          held_d = dir_q ^ shape_q[1];
        end else begin
          step_d = '0;
          if (shape_q[1]) begin
            dir_d = ~dir_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 16'd0;
      step_q    <= '0;
      dir_q     <= 1'b0;
      stop_q    <= 1'b1;
      held_q    <= 1'b0;
      shape_q   <= 4'd0;
      env_end_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      stop_q    <= stop_d;
      held_q    <= held_d;
      shape_q   <= shape_d;
      env_end_q <= env_end_d;
    end
  end

  // dir=1 means rising (level follows step), dir=0 means falling.
  assign bus.env     = stop_q ? (held_q ? MAX : '0)
                              : (dir_q ? step_q : MAX - step_q);
  assign bus.env_end = env_end_q;

endmodule

// File: tb/tb_psg_env_gen.sv
// -----------------------------------------------------------------------------
// tb_psg_env_gen
//
// Drives two envelope generators (EW=5 and EW=4) from the same stimulus and
// checks both against a tick-count model: the level is derived from how many
// ticks have elapsed since the last restart and which ramp that falls in.
// Directed literal checks pin the model at hand-computed points.
// -----------------------------------------------------------------------------
module tb_psg_env_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen256 = 1'b0;
  logic [15:0] period = 16'd1;
  logic [3:0]  shape = 4'd0;
  logic        restart = 1'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  psg_env_gen_if #(.EW(5)) bus5 ();
  psg_env_gen_if #(.EW(4)) bus4 ();

  assign bus5.cen256  = cen256;
  assign bus5.period  = period;
  assign bus5.shape   = shape;
  assign bus5.restart = restart;
  assign bus4.cen256  = cen256;
  assign bus4.period  = period;
  assign bus4.shape   = shape;
  assign bus4.restart = restart;

  psg_env_gen #(.EW(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  psg_env_gen #(.EW(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  // Model state: index 0 is the 32-step instance, index 1 the 16-step one.
  int       m_max [2] = '{31, 15};
  bit       m_started [2] = '{1'b0, 1'b0};
  int       m_ticks [2] = '{0, 0};
  bit [3:0] m_shape [2] = '{4'd0, 4'd0};
  bit       m_end [2] = '{1'b0, 1'b0};
  int       m_strobes = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // True once the envelope has nothing more to do until the next restart.
  function automatic bit m_stopped(input int k);
    if (!m_started[k]) return 1'b1;
    if (m_ticks[k] >= m_max[k] + 1 && !(m_shape[k][3] && !m_shape[k][0])) return 1'b1;
    return 1'b0;
  endfunction

  // Level after m_ticks ticks: ramp number and position within the ramp.
  function automatic int m_env(input int k);
    int span;
    int ramp;
    int pos;
    bit up;
    if (!m_started[k]) return 0;
    span = m_max[k] + 1;
    ramp = m_ticks[k] / span;
    pos  = m_ticks[k] % span;
    if (ramp >= 1 && !m_shape[k][3]) return 0;
    if (ramp >= 1 && m_shape[k][0]) return (m_shape[k][2] ^ m_shape[k][1]) ? m_max[k] : 0;
    up = m_shape[k][2] ^ (m_shape[k][1] & ramp[0]);
    return up ? pos : m_max[k] - pos;
  endfunction

  // Model update on every clock edge and on the asynchronous reset.
  initial begin
    bit tick;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_strobes = 0;
        for (int k = 0; k < 2; k++) begin
          m_started[k] = 1'b0;
          m_ticks[k]   = 0;
          m_shape[k]   = 4'd0;
          m_end[k]     = 1'b0;
        end
      end else begin
        tick = 1'b0;
        if (cen256) begin
          if (m_strobes + 1 >= ((period == 16'd0) ? 1 : int'(period))) begin
            tick = 1'b1;
            m_strobes = 0;
          end else begin
            m_strobes++;
          end
        end
        if (restart) m_strobes = 0;
        for (int k = 0; k < 2; k++) begin
          m_end[k] = 1'b0;
          if (restart) begin
            m_started[k] = 1'b1;
            m_ticks[k]   = 0;
            m_shape[k]   = shape;
          end else if (tick && !m_stopped(k)) begin
            m_ticks[k]++;
            if (m_ticks[k] % (m_max[k] + 1) == 0) m_end[k] = 1'b1;
          end
        end
      end
    end
  end

  // Compare both instances against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("env_ew5",     int'(bus5.env),     m_env(0));
      checkOutput("env_end_ew5", int'(bus5.env_end), int'(m_end[0]));
      checkOutput("env_ew4",     int'(bus4.env),     m_env(1));
      checkOutput("env_end_ew4", int'(bus4.env_end), int'(m_end[1]));
    end
  end

  // Optional restart pulse (with cen256 low), then clks cycles with a strobe
  // every cen_every clocks (0 = no strobes). Returns #1 after the last edge.
  task automatic applyStimulus(input logic [15:0] per, input logic [3:0] shp,
                               input bit do_restart, input int cen_every, input int clks);
    period = per;
    shape  = shp;
    if (do_restart) begin
      restart = 1'b1;
      cen256  = 1'b0;
      @(posedge clk);
      #1;
      restart = 1'b0;
    end
    for (int i = 0; i < clks; i++) begin
      cen256 = (cen_every > 0) && (i % cen_every == 0);
      @(posedge clk);
      #1;
    end
    cen256 = 1'b0;
  endtask

  task automatic checkPair(input string name, input int exp5, input int exp4);
    checkOutput({name, "_ew5"}, int'(bus5.env), exp5);
    checkOutput({name, "_ew4"}, int'(bus4.env), exp4);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkPair("reset_env", 0, 0);
    checkOutput("reset_env_end", int'(bus5.env_end), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Rise then hold high (0xD)
    applyStimulus(16'd1, 4'hD, 1'b1, 1, 16);
    checkPair("d_at16", 16, 15);
    checkOutput("d_end_ew4", int'(bus4.env_end), 1);
    applyStimulus(16'd1, 4'hD, 1'b0, 1, 16);
    checkPair("d_at32", 31, 15);
    checkOutput("d_end_ew5", int'(bus5.env_end), 1);
    checkOutput("d_noend_ew4", int'(bus4.env_end), 0);
    applyStimulus(16'd1, 4'hD, 1'b0, 1, 8);
    checkPair("d_held", 31, 15);

    // Repeating falling saw (0x8), period 2, strobe every 4 clks
    applyStimulus(16'd2, 4'h8, 1'b1, 4, 64);
    checkPair("saw_64", 23, 7);
    applyStimulus(16'd2, 4'h8, 1'b0, 4, 536);
    checkPair("saw_600", 20, 4);

    // Triangle starting downward (0xA)
    applyStimulus(16'd1, 4'hA, 1'b1, 1, 40);
    checkPair("tri_a_40", 8, 7);

    // One-shot shapes end at 0 and stay there
    applyStimulus(16'd1, 4'h0, 1'b1, 1, 1100);
    checkPair("shape0_end", 0, 0);
    applyStimulus(16'd1, 4'h4, 1'b1, 1, 5);
    checkPair("shape4_rise", 5, 5);
    applyStimulus(16'd1, 4'h4, 1'b0, 1, 1095);
    checkPair("shape4_end", 0, 0);

    // Fall then hold high (0xB)
    applyStimulus(16'd1, 4'hB, 1'b1, 1, 40);
    checkPair("shapeb_held", 31, 15);

    // Period 0 ticks like period 1; no ticks without strobes
    applyStimulus(16'd0, 4'hD, 1'b1, 1, 10);
    checkPair("period0", 10, 10);
    applyStimulus(16'd1, 4'hD, 1'b1, 0, 20);
    checkPair("no_cen", 0, 0);

    // Shrinking the period mid-count ticks on the next strobe
    applyStimulus(16'd100, 4'hD, 1'b1, 1, 50);
    checkPair("p100_cnt50", 0, 0);
    applyStimulus(16'd10, 4'hD, 1'b0, 1, 1);
    checkPair("p10_tick", 1, 1);
    applyStimulus(16'd10, 4'hD, 1'b0, 1, 10);
    checkPair("p10_next", 2, 2);

    // Restart coincident with a tick at step 17
    applyStimulus(16'd1, 4'hD, 1'b1, 1, 17);
    checkPair("pre_restart", 17, 15);
    shape   = 4'hD;
    restart = 1'b1;
    cen256  = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    cen256  = 1'b0;
    checkPair("restart_tick", 0, 0);
    applyStimulus(16'd1, 4'hD, 1'b0, 0, 3);
    checkPair("restart_idle", 0, 0);

    // Asynchronous reset mid-ramp
    applyStimulus(16'd1, 4'hD, 1'b0, 1, 10);
    checkPair("pre_reset", 10, 10);
    #2;
    rst_n = 1'b0;
    #1;
    checkPair("async_reset", 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(16'd1, 4'hD, 1'b0, 1, 20);
    checkPair("post_reset", 0, 0);

    // Rising-first triangle (0xE)
    applyStimulus(16'd1, 4'hE, 1'b1, 1, 20);
    checkPair("tri_e_20", 20, 11);
    applyStimulus(16'd1, 4'hE, 1'b0, 1, 40);
    checkPair("tri_e_60", 3, 3);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/psg_env_gen.md
Name: psg_env_gen

Overview:
- Envelope generator for the YM2149-compatible PSG.
- Sits directly downstream of the clock-enable divider and consumes its cen256 strobe.
- Produces the envelope level used by the channel amplitude mux whenever a channel selects envelope mode.
- Implements the 16-bit envelope period divider, the EW-bit step counter and the four shape bits (CONT, ATT, ALT, HOLD) with restart on shape-register write.

Parameters:
- EW, 5, envelope level/step width; 5 = YM2149 32-step, 4 = AY-3-8910 16-step. MAX = 2^EW-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen256  in  1  clock enable from the divider; one-clk strobe, envelope time base
- period  in  16  envelope period (R13:R14 on the register file); 0 is treated as 1
- shape  in  4  [3]=CONT [2]=ATT [1]=ALT [0]=HOLD; sampled only on restart
- restart  in  1  one-clk pulse on any write to the shape register
- env  out  EW  current envelope level
- env_end  out  1  one-clk strobe when a 32-step (or 16-step) cycle completes

Behaviour:
- Reset (rst_n=0, async):
  - cnt=0, step=0, dir=0, stop=1, held=0, shape_q=0, env_end=0.
  - Result: env=0.
- All state updates on posedge clk. env is combinational from registers: env = stop ? held : (dir ? step : MAX-step).
- Period divider:
  - On cen256, if cnt+1 >= max(period,1) then tick=1 and cnt<=0; else cnt<=cnt+1.
  - One tick every max(period,1) cen256 strobes. No tick without cen256.
- Period change mid-count: the >= comparison guarantees a tick on the next cen256 if cnt already meets or exceeds the new period-1. No wrap to 65535.
- Restart (highest priority, overrides a coincident tick):
  - cnt<=0, step<=0, dir<=shape[2], stop<=0, shape_q<=shape, env_end<=0.
  - env shows the first level (0 or MAX) on the clk after restart.
- Tick with stop=1: no state change.
- Tick with stop=0 and step<MAX: step<=step+1.
- Tick with stop=0 and step==MAX (end of cycle): env_end<=1 for one clk, then by shape_q:
  - CONT=0: stop<=1, held<=0. Shapes 0-7 end at 0 regardless of ATT.
  - CONT=1, HOLD=1: stop<=1, held <= (dir ^ ALT) ? MAX : 0.
  - CONT=1, HOLD=0: step<=0; if ALT then dir<=~dir. Repeats indefinitely.
- env_end is 0 in every other cycle. It is not asserted when stop=1.
- period and shape may change at any time. shape has no effect until the next restart. period takes effect at the next cen256.
- Reset mid-cycle returns to the reset state immediately; no restart is needed to resume output 0.
- Synthesisable with no latches; cnt is 16 bits, step is EW bits, all arithmetic unsigned.

Test Plan:
- Reset, then restart with shape=0xD, period=1, cen256 every clk -> env 0,1,...,31 on consecutive clks, then holds 31; env_end pulses once.
- shape=0x8, period=2, cen256 every 4 clks -> env 31,30,...,0 with each level lasting 8 clks, then wraps to 31; env_end every 256 clks.
- shape=0xA, period=1 -> triangle 31..0 then 0..31 then 31..0; dir toggles at each env_end.
- shape=0x0 and shape=0x4 -> after 32 ticks env=0 and stays 0 for more than 1000 further ticks. shape=0xB -> falls to 0, then holds 31.
- period=0 vs period=1 -> identical tick rate. period=100 with cnt=50 when period is changed to 10 -> tick on the next cen256.
- restart coincident with a tick mid-ramp (step=17) -> step=0, cnt=0 and no increment. rst_n pulsed low mid-ramp -> env=0 asynchronously; stop=1 until the next restart.
- EW=4 build, shape=0xE -> triangle 0..15..0 with a 16-step period.
